alu_share_arb: RTL and testbench

//  Shares one 10-bit signed ALU (proj1: ADD/SUB/MAX/MIN/AND/ORR/XOR/XNOR, flags {NEG,POS,ZERO,OVF})

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/alu_share_arb_proj1.sv | 44 ++++
 rtl/alu_share_arb_rr_arbiter.sv | 38 +++
 rtl/alu_share_arb.sv | 171 +++++++++++++++++
 tb/tb_alu_share_arb.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
//   - ALU operand/opcode/flag widths
//   - opcode constants (OP_ADD .. OP_XNOR)
//   - flag bit positions inside the 4-bit {NEG,POS,ZERO,OVF} flag word
//   - FSM state encoding used by alu_share_arb (also visible on its debug port)
package alu_pkg;

  localparam int DATA_W = 10;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_MAX  = 3'd2;
  localparam logic [OP_W-1:0] OP_MIN  = 3'd3;
  localparam logic [OP_W-1:0] OP_AND  = 3'd4;
  localparam logic [OP_W-1:0] OP_ORR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd6;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd7;

  localparam int FLG_NEG  = 3;
  localparam int FLG_POS  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_OVF  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Builds the flag word from a result and its overflow bit.
  function automatic logic [FLAG_W-1:0] make_flags(input logic [DATA_W-1:0] res,
                                                   input logic ovf);
    logic [FLAG_W-1:0] f;
    f           = '0;
    f[FLG_NEG]  = res[DATA_W-1];
    f[FLG_ZERO] = (res == '0);
    f[FLG_POS]  = !res[DATA_W-1] && (res != '0);
    f[FLG_OVF]  = ovf;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_arb_proj1.sv
// proj1: combinational 10-bit signed ALU.
// Ports:
//   i_arg0, i_arg1 : signed operands (two's complement, 10 bits)
//   i_oper         : opcode (OP_ADD .. OP_XNOR)
//   o_result       : 10-bit result (ADD/SUB wrap modulo 2^10)
//   o_flag         : {NEG,POS,ZERO,OVF}; OVF only meaningful for ADD/SUB
module proj1
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_arg0,
  input  logic [DATA_W-1:0] i_arg1,
  input  logic [OP_W-1:0]   i_oper,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flag
);

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              ovf_add;
  logic              ovf_sub;
  logic              ovf;

  always_comb begin
    sum  = i_arg0 + i_arg1;
    diff = i_arg0 - i_arg1;
    // Signed overflow: result sign disagrees with what the operand signs allow.
    ovf_add = (i_arg0[DATA_W-1] == i_arg1[DATA_W-1]) && (sum[DATA_W-1]  != i_arg0[DATA_W-1]);
    ovf_sub = (i_arg0[DATA_W-1] != i_arg1[DATA_W-1]) && (diff[DATA_W-1] != i_arg0[DATA_W-1]);
    ovf      = 1'b0;
    o_result = '0;
    case (i_oper)
      OP_ADD:  begin o_result = sum;  ovf = ovf_add; end
      OP_SUB:  begin o_result = diff; ovf = ovf_sub; end
      OP_MAX:  o_result = ($signed(i_arg0) > $signed(i_arg1)) ? i_arg0 : i_arg1;
      OP_MIN:  o_result = ($signed(i_arg0) < $signed(i_arg1)) ? i_arg0 : i_arg1;
      OP_AND:  o_result = i_arg0 & i_arg1;
      OP_ORR:  o_result = i_arg0 | i_arg1;
      OP_XOR:  o_result = i_arg0 ^ i_arg1;
      default: o_result = ~(i_arg0 ^ i_arg1);
    endcase
    o_flag = make_flags(o_result, ovf);
  end

endmodule

// File: rtl/alu_share_arb_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Ports:
//   i_req      : request vector
//   i_last     : index of the most recently served requester
//   o_grant    : one-hot grant (zero when no request)
//   o_grant_id : encoded grant index
//   o_any      : at least one request present
// Search order is last+1, last+2, ... wrapping modulo N_REQ, so the
// requester served last has the lowest priority.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_any
);

  int idx;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    idx        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(i_last) + i) % N_REQ;
      if (!o_any && i_req[idx]) begin
        o_any        = 1'b1;
        o_grant[idx] = 1'b1;
        o_grant_id   = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// alu_share_arb: shares one proj1 ALU between N_REQ requesters.
// Ports:
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req_valid/o_req_ready, i_req_arg0/arg1/oper : per-requester op channels
//   o_rsp_valid/i_rsp_ready, o_rsp_result/flag/id : shared response channel
//   i_ovf_clr, o_ovf_sticky : per-requester sticky overflow status
//   o_dbg_state           : current FSM state (alu_pkg::state_t encoding)
// Optional feature: define ALU_ARB_STICKY_OVF_EN to enable sticky overflow
// tracking; otherwise o_ovf_sticky is 0 and i_ovf_clr is ignored.
//
// Handshake: a channel transfers on the cycle where valid & ready are both
// high. Requesters keep valid and operands stable until transfer and never
// wait on ready; o_req_ready is combinational from state, valids and the
// round-robin pointer, and the response outputs stay stable while
// o_rsp_valid is high and i_rsp_ready is low.
module alu_share_arb
  import alu_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req_valid,
  input  logic [DATA_W*N_REQ-1:0] i_req_arg0,
  input  logic [DATA_W*N_REQ-1:0] i_req_arg1,
  input  logic [OP_W*N_REQ-1:0]   i_req_oper,
  output logic [N_REQ-1:0]        o_req_ready,
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [DATA_W-1:0]       o_rsp_result,
  output logic [FLAG_W-1:0]       o_rsp_flag,
  output logic [ID_W-1:0]         o_rsp_id,
  input  logic [N_REQ-1:0]        i_ovf_clr,
  output logic [N_REQ-1:0]        o_ovf_sticky,
  output logic [1:0]              o_dbg_state
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] arg0_q, arg0_d;
  logic [DATA_W-1:0] arg1_q, arg1_d;
  logic [OP_W-1:0]   oper_q, oper_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0] rsp_flag_q, rsp_flag_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [N_REQ-1:0]  sticky_q, sticky_d;

  logic [N_REQ-1:0]  arb_grant;
  logic [ID_W-1:0]   arb_id;
  logic              arb_any;
  logic              can_accept;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flag;

  rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req      (i_req_valid),
    .i_last     (last_q),
    .o_grant    (arb_grant),
    .o_grant_id (arb_id),
    .o_any      (arb_any)
  );

  proj1 u_alu (
    .i_arg0   (arg0_q),
    .i_arg1   (arg1_q),
    .i_oper   (oper_q),
    .o_result (alu_result),
    .o_flag   (alu_flag)
  );

  always_comb begin
    // A new op may enter when idle, or when the pending response leaves
    // this very cycle, which gives back-to-back ops every two cycles.
    can_accept  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && i_rsp_ready);
    accept      = can_accept && arb_any;
    o_req_ready = accept ? arb_grant : '0;

    state_d      = state_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    oper_d       = oper_q;
    id_d         = id_q;
    last_d       = last_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    rsp_id_d     = rsp_id_q;

    if (accept) begin
      arg0_d = i_req_arg0[DATA_W*int'(arb_id) +: DATA_W];
      arg1_d = i_req_arg1[DATA_W*int'(arb_id) +: DATA_W];
      oper_d = i_req_oper[OP_W*int'(arb_id) +: OP_W];
      id_d   = arb_id;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        rsp_result_d = alu_result;
        rsp_flag_d   = alu_flag;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        last_d       = id_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? ST_EXEC : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ALU_ARB_STICKY_OVF_EN
  logic [N_REQ-1:0] ovf_set;
  always_comb begin
    ovf_set = '0;
    if (rsp_valid_q && i_rsp_ready && rsp_flag_q[FLG_OVF]) ovf_set[rsp_id_q] = 1'b1;
    // Set is OR-ed in after the clear so a simultaneous set wins.
    sticky_d = (sticky_q & ~i_ovf_clr) | ovf_set;
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^i_ovf_clr;
  assign sticky_d       = '0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      arg0_q       <= '0;
      arg1_q       <= '0;
      oper_q       <= '0;
      id_q         <= '0;
      last_q       <= ID_W'(N_REQ - 1);
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_flag_q   <= '0;
      rsp_id_q     <= '0;
      sticky_q     <= '0;
    end else begin
      state_q      <= state_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      oper_q       <= oper_d;
      id_q         <= id_d;
      last_q       <= last_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
      rsp_id_q     <= rsp_id_d;
      sticky_q     <= sticky_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_flag   = rsp_flag_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_ovf_sticky = sticky_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios followed by random traffic,
// checked each cycle against a transaction-level reference model.
module tb_alu_share_arb;
  import alu_pkg::*;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int EXP_W = ID_W + 4 + 10;
  localparam int M_FREE = 0;
  localparam int M_EXEC = 1;
  localparam int M_RESP = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]    req_valid;
  logic [10*N_REQ-1:0] req_arg0;
  logic [10*N_REQ-1:0] req_arg1;
  logic [3*N_REQ-1:0]  req_oper;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [9:0]          rsp_result;
  logic [3:0]          rsp_flag;
  logic [ID_W-1:0]     rsp_id;
  logic [N_REQ-1:0]    ovf_clr;
  logic [N_REQ-1:0]    ovf_sticky;
  logic [1:0]          dbg_state;

  alu_share_arb #(.N_REQ(N_REQ)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_arg0   (req_arg0),
    .i_req_arg1   (req_arg1),
    .i_req_oper   (req_oper),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_result (rsp_result),
    .o_rsp_flag   (rsp_flag),
    .o_rsp_id     (rsp_id),
    .i_ovf_clr    (ovf_clr),
    .o_ovf_sticky (ovf_sticky),
    .o_dbg_state  (dbg_state)
  );

  // scoreboard
  logic [EXP_W-1:0] exp_q[$];
  int               n_checks = 0;
  int               n_err    = 0;
  logic [N_REQ-1:0] acc_mask = '0;

  // reference model state: transaction-level view
  int               m_state  = M_FREE;
  int               m_last   = N_REQ - 1;
  logic [N_REQ-1:0] m_sticky = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU computed with integer arithmetic.
  function automatic logic [EXP_W-1:0] model_op(input int id, input logic [9:0] a,
                                                input logic [9:0] b, input logic [2:0] op);
    int         sa, sb, r, rs;
    logic       ovf;
    logic [9:0] rv;
    logic [ID_W-1:0] idv;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    ovf = 1'b0;
    r   = 0;
    rv  = '0;
    case (op)
      3'd0: begin r = sa + sb; ovf = (r > 511) || (r < -512); rv = r[9:0]; end
      3'd1: begin r = sa - sb; ovf = (r > 511) || (r < -512); rv = r[9:0]; end
      3'd2: rv = (sa > sb) ? a : b;
      3'd3: rv = (sa < sb) ? a : b;
      3'd4: rv = a & b;
      3'd5: rv = a | b;
      3'd6: rv = a ^ b;
      default: rv = ~(a ^ b);
    endcase
    rs  = int'($signed(rv));
    idv = id[ID_W-1:0];
    return {idv, (rs < 0), (rs > 0), (rs == 0), ovf, rv};
  endfunction

  function automatic logic [1:0] model_enc(input int s);
    case (s)
      M_EXEC:  return ST_EXEC;
      M_RESP:  return ST_RESP;
      default: return ST_IDLE;
    endcase
  endfunction

  // monitor: sample mid-cycle, compare, then advance the model
  always @(negedge clk) begin
    logic [EXP_W-1:0] head;
    logic             xfer, allow;
    int               gid, k;
    logic [N_REQ-1:0] exp_ready, set_v;
    if (rst) begin
      m_state  = M_FREE;
      m_last   = N_REQ - 1;
      m_sticky = '0;
      acc_mask = '0;
      exp_q.delete();
    end else begin
      chk("dbg_state", 32'(dbg_state), 32'(model_enc(m_state)));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_state == M_RESP));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL rsp_unexpected: got response id %0d, expected none", rsp_id);
        end else begin
          head = exp_q[0];
          chk("rsp_result", 32'(rsp_result), 32'(head[9:0]));
          chk("rsp_flag",   32'(rsp_flag),   32'(head[13:10]));
          chk("rsp_id",     32'(rsp_id),     32'(head[EXP_W-1 -: ID_W]));
        end
      end
      chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));

      xfer  = (m_state == M_RESP) && rsp_ready;
      allow = (m_state == M_FREE) || xfer;
      gid   = -1;
      for (int i = 1; i <= N_REQ; i++) begin
        k = (m_last + i) % N_REQ;
        if (gid < 0 && req_valid[k]) gid = k;
      end
      exp_ready = '0;
      if (allow && gid >= 0) exp_ready[gid] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      acc_mask = req_valid & req_ready;

      set_v = '0;
      if (xfer && exp_q.size() > 0) begin
        head = exp_q.pop_front();
        if (head[10]) set_v[head[EXP_W-1 -: ID_W]] = 1'b1;
      end
`ifdef ALU_ARB_STICKY_OVF_EN
      m_sticky = (m_sticky & ~ovf_clr) | set_v;
`else
      m_sticky = '0;
`endif
      if (allow && gid >= 0) begin
        exp_q.push_back(model_op(gid, req_arg0[10*gid +: 10], req_arg1[10*gid +: 10],
                                 req_oper[3*gid +: 3]));
        m_last = gid;
      end
      case (m_state)
        M_EXEC:  m_state = M_RESP;
        M_RESP:  if (xfer) m_state = (allow && gid >= 0) ? M_EXEC : M_FREE;
        default: m_state = (allow && gid >= 0) ? M_EXEC : M_FREE;
      endcase
    end
  end

  // driver tasks
  task automatic set_op(input int k, input int a, input int b, input logic [2:0] op);
    req_arg0[10*k +: 10] = a[9:0];
    req_arg1[10*k +: 10] = b[9:0];
    req_oper[3*k +: 3]   = op;
  endtask

  task automatic rand_op(input int k);
    logic [9:0] edge_v[5];
    edge_v = '{10'h1FF, 10'h200, 10'h3FF, 10'h000, 10'h001};
    req_arg0[10*k +: 10] = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)]
                                                        : 10'($urandom_range(0, 1023));
    req_arg1[10*k +: 10] = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)]
                                                        : 10'($urandom_range(0, 1023));
    req_oper[3*k +: 3]   = 3'($urandom_range(0, 7));
  endtask

  // Raise the masked valids and wait until every one of them has transferred.
  task automatic wait_accept(input logic [N_REQ-1:0] mask);
    logic [N_REQ-1:0] pend, done;
    int               n;
    pend = mask;
    n    = 0;
    req_valid = req_valid | mask;
    while (pend != '0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      done      = acc_mask & pend;
      req_valid = req_valid & ~done;
      pend      = pend & ~done;
    end
    if (pend != '0) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout: pending %b, expected none", pend);
      req_valid = req_valid & ~pend;
    end
  endtask

  task automatic issue(input int k, input int a, input int b, input logic [2:0] op);
    logic [N_REQ-1:0] m;
    set_op(k, a, b, op);
    m    = '0;
    m[k] = 1'b1;
    wait_accept(m);
  endtask

  task automatic auto_cycles(input int n, input int p_new, input int p_ready,
                             input int p_drop, input int p_clr);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < N_REQ; k++) begin
        if (acc_mask[k]) req_valid[k] = 1'b0;
        if (!req_valid[k]) begin
          if ($urandom_range(0, 99) < p_new) begin
            rand_op(k);
            req_valid[k] = 1'b1;
          end
        end else if ($urandom_range(0, 99) < p_drop) begin
          req_valid[k] = 1'b0;
        end
        ovf_clr[k] = ($urandom_range(0, 99) < p_clr);
      end
      rsp_ready = ($urandom_range(0, 99) < p_ready);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_arg0  = '0;
    req_arg1  = '0;
    req_oper  = '0;
    rsp_ready = 1'b1;
    ovf_clr   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_flag",   32'(rsp_flag),   32'd0);
    chk("rst_id",     32'(rsp_id),     32'd0);
    @(posedge clk);
    #1;

    // basic arithmetic including wrap and overflow
    issue(0, 100, 50, OP_ADD);
    issue(1, 300, 300, OP_ADD);
    issue(1, -512, 1, OP_SUB);
    repeat (3) @(posedge clk);
    #1;

    // all requesters valid straight out of reset
    rst = 1'b1;
    for (int k = 0; k < N_REQ; k++) rand_op(k);
    req_valid = '1;
    @(posedge clk);
    #1 rst = 1'b0;
    auto_cycles(20, 100, 100, 0, 0);
    req_valid = '0;
    rsp_ready = 1'b1;
    ovf_clr   = '0;
    repeat (4) @(posedge clk);
    #1;

    // stalled response, then accept in the release cycle
    issue(0, 7, -3, OP_MAX);
    rsp_ready = 1'b0;
    set_op(3, -20, 5, OP_MIN);
    req_valid[3] = 1'b1;
    repeat (7) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_accept(4'b1000);
    repeat (3) @(posedge clk);
    #1;

    // reset during EXEC discards the op; pointer returns to N_REQ-1
    issue(2, 1, 2, OP_ADD);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    set_op(0, 5, 5, OP_XOR);
    set_op(3, 5, 6, OP_ORR);
    wait_accept(4'b1001);
    repeat (4) @(posedge clk);
    #1;

    // sticky overflow: set, set-wins-over-clear, clear alone
    issue(2, 300, 300, OP_ADD);
    repeat (3) @(posedge clk);
    #1 ovf_clr = 4'b0100;
    issue(2, -300, 300, OP_SUB);
    repeat (3) @(posedge clk);
    #1 ovf_clr = 4'b0000;
    repeat (2) @(posedge clk);
    #1 ovf_clr = 4'b0100;
    @(posedge clk);
    #1 ovf_clr = 4'b0000;
    repeat (2) @(posedge clk);
    #1;

    // random traffic with backpressure, drops and clears
    auto_cycles(3000, 40, 70, 5, 10);

    // drain
    req_valid = '0;
    rsp_ready = 1'b1;
    ovf_clr   = '0;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while ((exp_q.size() != 0 || rsp_valid) && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        n_err++;
        $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
